// File: rtl/unidade_busca.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | unidade_busca : Redux-V instruction fetch stage (PC, IR, valid/ready,     |
// |                 stall, redirect with flush, halt on opcode).              |
// | Option macro  : FETCH_STATS_EN adds the 16-bit num_inst handshake count.  |
// | Revision      : 1.0  initial release                                     |
// +--------------------------------------------------------------------------+
module unidade_busca #(
  parameter int                   LARG_END    = 8,
  parameter int                   LARG_INST   = 8,
  parameter logic [LARG_INST-1:0] HALT_OPCODE = 8'hFF,
  parameter logic [LARG_END-1:0]  END_INICIAL = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iniciar,
  output logic [LARG_END-1:0]  endereco,
  input  logic [LARG_INST-1:0] instrucao,
  output logic [LARG_INST-1:0] inst_saida,
  output logic [LARG_END-1:0]  pc_inst,
  output logic                 inst_valido,
  input  logic                 inst_pronto,
  input  logic                 desvio,
  input  logic [LARG_END-1:0]  desvio_alvo,
  output logic                 parado
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]          num_inst
`endif
);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    BUSCA  = 2'd1,
    FIM    = 2'd2
  } estado_t;

  estado_t              r_estado, w_estado_prox;
  logic [LARG_END-1:0]  r_pc, w_pc;
  logic [LARG_INST-1:0] r_inst, w_inst;
  logic [LARG_END-1:0]  r_pc_inst, w_pc_inst;
  logic                 r_valido, w_valido;
  logic                 r_parado, w_parado;
  logic                 w_slot_livre;

  assign w_slot_livre = !r_valido || inst_pronto;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_estado  <= OCIOSO;
      r_pc      <= END_INICIAL;
      r_inst    <= '0;
      r_pc_inst <= '0;
      r_valido  <= 1'b0;
      r_parado  <= 1'b0;
    end else begin
      r_estado  <= w_estado_prox;
      r_pc      <= w_pc;
      r_inst    <= w_inst;
      r_pc_inst <= w_pc_inst;
      r_valido  <= w_valido;
      r_parado  <= w_parado;
    end
  end

  always_comb begin
    w_estado_prox = r_estado;
    w_pc          = r_pc;
    w_inst        = r_inst;
    w_pc_inst     = r_pc_inst;
    w_valido      = r_valido;
    w_parado      = r_parado;
    case (r_estado)
      OCIOSO: begin
        if (iniciar) w_estado_prox = BUSCA;
      end
      BUSCA: begin
        if (desvio) begin
          // Redirect wins even over an accepting decoder: the held instruction is wrong-path.
          w_pc     = desvio_alvo;
          w_valido = 1'b0;
        end else if (w_slot_livre) begin
          w_inst    = instrucao;
          w_pc_inst = r_pc;
          w_valido  = 1'b1;
          if (instrucao == HALT_OPCODE) begin
            w_estado_prox = FIM;
          end else begin
            w_pc = r_pc + 1'b1;
          end
        end
      end
      FIM: begin
        if (r_valido && inst_pronto) w_valido = 1'b0;
        if (w_slot_livre) w_parado = 1'b1;
      end
      default: begin
        w_estado_prox = OCIOSO;
      end
    endcase
  end

  assign endereco    = r_pc;
  assign inst_saida  = r_inst;
  assign pc_inst     = r_pc_inst;
  assign inst_valido = r_valido;
  assign parado      = r_parado;

`ifdef FETCH_STATS_EN
  logic [15:0] r_num_inst;
  logic        w_handshake;

  // A flushed instruction never reached the decoder, so it is not counted.
  assign w_handshake = r_valido && inst_pronto && !((r_estado == BUSCA) && desvio);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_num_inst <= 16'h0000;
    end else if (w_handshake && (r_num_inst != 16'hFFFF)) begin
      r_num_inst <= r_num_inst + 16'h0001;
    end
  end

  assign num_inst = r_num_inst;
`endif

endmodule
`default_nettype wire

// File: tb/tb_unidade_busca.sv
`default_nettype none
// Testbench for unidade_busca: directed scenarios plus a randomized run
// checked against a cycle-level reference model of the fetch rules.
module tb_unidade_busca;

  logic       clk = 1'b0;
  logic       rst_n, iniciar, inst_pronto, desvio;
  logic [7:0] desvio_alvo, endereco, instrucao, inst_saida, pc_inst;
  logic       inst_valido, parado;
`ifdef FETCH_STATS_EN
  logic [15:0] num_inst;
`endif

  logic [7:0] mem [256];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;
  assign instrucao = mem[endereco];

  unidade_busca dut (
    .clk(clk), .rst_n(rst_n), .iniciar(iniciar), .endereco(endereco),
    .instrucao(instrucao), .inst_saida(inst_saida), .pc_inst(pc_inst),
    .inst_valido(inst_valido), .inst_pronto(inst_pronto), .desvio(desvio),
    .desvio_alvo(desvio_alvo), .parado(parado)
`ifdef FETCH_STATS_EN
    , .num_inst(num_inst)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 254));
  endtask

  task automatic do_reset;
    rst_n = 1'b0; iniciar = 1'b0; inst_pronto = 1'b0; desvio = 1'b0; desvio_alvo = 8'h00;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic start;
    iniciar = 1'b1;
    tick;
    iniciar = 1'b0;
  endtask

  task automatic test_reset;
    fill_mem;
    do_reset;
    n_tests++;
    if ({endereco, inst_saida, pc_inst, inst_valido, parado} !== 26'h0) begin
      n_fail++;
      $display("FAIL reset_values got end=%h ir=%h pc=%h v=%b p=%b want all 0",
               endereco, inst_saida, pc_inst, inst_valido, parado);
    end
    inst_pronto = 1'b1; desvio = 1'b1; desvio_alvo = 8'h33;
    tick; tick;
    desvio = 1'b0;
    n_tests++;
    if (inst_valido !== 1'b0 || endereco !== 8'h00) begin
      n_fail++;
      $display("FAIL idle_no_capture got v=%b end=%h want v=0 end=00", inst_valido, endereco);
    end
  endtask

  task automatic test_stream;
    do_reset;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    inst_pronto = 1'b1;
    start;
    for (int k = 0; k < 4; k++) begin
      tick;
      n_tests++;
      if (inst_valido !== 1'b1 || pc_inst !== 8'(k) || inst_saida !== mem[k]) begin
        n_fail++;
        $display("FAIL stream_%0d got v=%b pc=%h ir=%h want v=1 pc=%h ir=%h",
                 k, inst_valido, pc_inst, inst_saida, 8'(k), mem[k]);
      end
    end
  endtask

  task automatic test_stall;
    do_reset;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    inst_pronto = 1'b1;
    start;
    tick; tick; tick;
    inst_pronto = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      n_tests++;
      if (inst_saida !== 8'h33 || pc_inst !== 8'h02 || endereco !== 8'h03 || inst_valido !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold_%0d got ir=%h pc=%h end=%h v=%b want 33 02 03 1",
                 k, inst_saida, pc_inst, endereco, inst_valido);
      end
    end
    inst_pronto = 1'b1;
    tick;
    n_tests++;
    if (inst_saida !== 8'h44 || pc_inst !== 8'h03 || inst_valido !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release got ir=%h pc=%h v=%b want 44 03 1", inst_saida, pc_inst, inst_valido);
    end
  endtask

  task automatic test_branch;
    fill_mem;
    do_reset;
    inst_pronto = 1'b1;
    start;
    tick; tick;
    desvio = 1'b1; desvio_alvo = 8'h40;
    tick;
    desvio = 1'b0;
    n_tests++;
    if (inst_valido !== 1'b0 || endereco !== 8'h40) begin
      n_fail++;
      $display("FAIL branch_flush got v=%b end=%h want v=0 end=40", inst_valido, endereco);
    end
    tick;
    n_tests++;
    if (inst_valido !== 1'b1 || pc_inst !== 8'h40 || inst_saida !== mem[8'h40]) begin
      n_fail++;
      $display("FAIL branch_target got v=%b pc=%h ir=%h want 1 40 %h",
               inst_valido, pc_inst, inst_saida, mem[8'h40]);
    end
  endtask

  task automatic test_halt;
    fill_mem;
    mem[5] = 8'hFF;
    do_reset;
    inst_pronto = 1'b1;
    start;
    for (int k = 0; k < 6; k++) tick;
    inst_pronto = 1'b0;
    n_tests++;
    if (inst_saida !== 8'hFF || pc_inst !== 8'h05 || inst_valido !== 1'b1 || endereco !== 8'h05) begin
      n_fail++;
      $display("FAIL halt_present got ir=%h pc=%h v=%b end=%h want FF 05 1 05",
               inst_saida, pc_inst, inst_valido, endereco);
    end
    tick; tick;
    n_tests++;
    if (inst_saida !== 8'hFF || inst_valido !== 1'b1 || endereco !== 8'h05 || parado !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_wait got ir=%h v=%b end=%h p=%b want FF 1 05 0",
               inst_saida, inst_valido, endereco, parado);
    end
    inst_pronto = 1'b1;
    tick;
    inst_pronto = 1'b0;
    n_tests++;
    if (inst_valido !== 1'b0 || parado !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_accept got v=%b p=%b want v=0 p=1", inst_valido, parado);
    end
    desvio = 1'b1; desvio_alvo = 8'h20; iniciar = 1'b1; inst_pronto = 1'b1;
    tick; tick;
    desvio = 1'b0; iniciar = 1'b0;
    n_tests++;
    if (endereco !== 8'h05 || inst_valido !== 1'b0 || parado !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_frozen got end=%h v=%b p=%b want 05 0 1", endereco, inst_valido, parado);
    end
  endtask

  task automatic test_midreset;
    fill_mem;
    do_reset;
    inst_pronto = 1'b1;
    start;
    tick; tick; tick;
    inst_pronto = 1'b0;
    tick; tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    n_tests++;
    if ({endereco, inst_saida, pc_inst, inst_valido, parado} !== 26'h0) begin
      n_fail++;
      $display("FAIL midreset_values got end=%h ir=%h pc=%h v=%b p=%b want all 0",
               endereco, inst_saida, pc_inst, inst_valido, parado);
    end
    inst_pronto = 1'b1;
    tick; tick; tick;
    n_tests++;
    if (inst_valido !== 1'b0 || endereco !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset_idle got v=%b end=%h want v=0 end=00", inst_valido, endereco);
    end
  endtask

  task automatic test_wrap;
    fill_mem;
    do_reset;
    inst_pronto = 1'b1;
    start;
    tick;
    desvio = 1'b1; desvio_alvo = 8'hFE + 8'h01;
    tick;
    desvio = 1'b0;
    tick;
    n_tests++;
    if (pc_inst !== 8'hFF || inst_saida !== mem[8'hFF] || inst_valido !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_ff got pc=%h ir=%h v=%b want FF %h 1", pc_inst, inst_saida, inst_valido, mem[8'hFF]);
    end
    tick;
    n_tests++;
    if (pc_inst !== 8'h00 || inst_saida !== mem[0] || endereco !== 8'h01) begin
      n_fail++;
      $display("FAIL wrap_00 got pc=%h ir=%h end=%h want 00 %h 01", pc_inst, inst_saida, endereco, mem[0]);
    end
`ifdef FETCH_STATS_EN
    do_reset;
    inst_pronto = 1'b1;
    start;
    for (int k = 0; k < 11; k++) tick;
    desvio = 1'b1; desvio_alvo = 8'h10;
    tick;
    desvio = 1'b0; inst_pronto = 1'b0;
    n_tests++;
    if (num_inst !== 16'd10) begin
      n_fail++;
      $display("FAIL stats_count got %0d want 10", num_inst);
    end
`endif
  endtask

  // Reference model: one call per clock edge, using the inputs present before the edge.
  logic [7:0]  m_pc, m_ir, m_pci;
  logic        m_valid, m_parado;
  int          m_mode;   // 0 idle, 1 fetching, 2 finished
  int unsigned m_cnt;

  task automatic model_edge;
    logic was_valid;
    was_valid = m_valid;
    if (!rst_n) begin
      m_pc = 8'h00; m_ir = 8'h00; m_pci = 8'h00; m_valid = 1'b0; m_parado = 1'b0;
      m_mode = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      if (iniciar) m_mode = 1;
    end else if (m_mode == 1) begin
      if (desvio) begin
        m_pc = desvio_alvo;
        m_valid = 1'b0;
      end else if (!was_valid || inst_pronto) begin
        if (was_valid && m_cnt < 65535) m_cnt++;
        m_ir = mem[m_pc];
        m_pci = m_pc;
        m_valid = 1'b1;
        if (m_ir == 8'hFF) m_mode = 2;
        else m_pc = m_pc + 8'h01;
      end
    end else begin
      if (was_valid && inst_pronto) begin
        if (m_cnt < 65535) m_cnt++;
        m_valid = 1'b0;
      end
      if (!was_valid || inst_pronto) m_parado = 1'b1;
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 47) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
    rst_n = 1'b0; iniciar = 1'b0; inst_pronto = 1'b0; desvio = 1'b0; desvio_alvo = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) begin
        rst_n       = ($urandom_range(0, 149) != 0);
        iniciar     = ($urandom_range(0, 3) == 0);
        inst_pronto = ($urandom_range(0, 3) != 0);
        desvio      = ($urandom_range(0, 11) == 0);
        desvio_alvo = 8'($urandom);
      end
      model_edge;
      tick;
      n_tests++;
      if (endereco !== m_pc || inst_valido !== m_valid || parado !== m_parado ||
          inst_saida !== m_ir || pc_inst !== m_pci) begin
        n_fail++;
        $display("FAIL random_c%0d got end=%h v=%b p=%b ir=%h pc=%h want %h %b %b %h %h",
                 c, endereco, inst_valido, parado, inst_saida, pc_inst,
                 m_pc, m_valid, m_parado, m_ir, m_pci);
      end
`ifdef FETCH_STATS_EN
      n_tests++;
      if (num_inst !== 16'(m_cnt)) begin
        n_fail++;
        $display("FAIL random_cnt_c%0d got %0d want %0d", c, num_inst, m_cnt);
      end
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0; iniciar = 1'b0; inst_pronto = 1'b0; desvio = 1'b0; desvio_alvo = 8'h00;
    test_reset;
    test_stream;
    test_stall;
    test_branch;
    test_halt;
    test_midreset;
    test_wrap;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
